bch_syndrome_seq: RTL and testbench

//  Sequential syndrome generator for the BCH(15,7) double-error-correcting decoder; sits directly

---
 rtl/bch_pkg.sv | 29 ++
 rtl/bch_syndrome_seq_step.sv | 37 +++
 rtl/bch_syndrome_seq.sv | 103 ++++++++++
 tb/tb_bch_syndrome_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared GF(16) constants, FSM state type and constant multipliers for the BCH(15,7) decoder chain.
// Field is GF(2^4) generated by x^4+x+1; elements are 4-bit polynomial-basis vectors.
package bch_pkg;

  localparam int GF_M = 4;
  localparam int BCH_N = 15;
  localparam int BCH_K = 7;
  localparam logic [4:0] PRIM_POLY = 5'b10011;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Multiply by a: shift up, fold x^4 back as x+1.
  function automatic logic [GF_M-1:0] gf_mul_a(input logic [GF_M-1:0] s);
    return {s[2:0], 1'b0} ^ (s[3] ? PRIM_POLY[3:0] : 4'h0);
  endfunction

  function automatic logic [GF_M-1:0] gf_mul_a2(input logic [GF_M-1:0] s);
    return {s[1], s[0] ^ s[3], s[3] ^ s[2], s[2]};
  endfunction

  function automatic logic [GF_M-1:0] gf_mul_a3(input logic [GF_M-1:0] s);
    return {s[0] ^ s[3], s[3] ^ s[2], s[2] ^ s[1], s[1]};
  endfunction

endpackage

// File: rtl/bch_syndrome_seq_step.sv
// Combinational Horner fold of BITS_PER_CYCLE received bits, highest index first,
// into the three running syndromes.
module bch_syn_step
  import bch_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BCH_N-1:0] word_i,
  input  logic [3:0]       cnt_i,
  input  logic [GF_M-1:0]  s1_i,
  input  logic [GF_M-1:0]  s2_i,
  input  logic [GF_M-1:0]  s3_i,
  output logic [GF_M-1:0]  s1_o,
  output logic [GF_M-1:0]  s2_o,
  output logic [GF_M-1:0]  s3_o
);

  logic [GF_M-1:0] t1, t2, t3;
  logic [3:0]      idx;

  always_comb begin
    t1  = s1_i;
    t2  = s2_i;
    t3  = s3_i;
    idx = cnt_i;
    for (int n = 0; n < BITS_PER_CYCLE; n++) begin
      idx = cnt_i - 4'(n);
      t1  = gf_mul_a(t1)  ^ {3'b000, word_i[idx]};
      t2  = gf_mul_a2(t2) ^ {3'b000, word_i[idx]};
      t3  = gf_mul_a3(t3) ^ {3'b000, word_i[idx]};
    end
    s1_o = t1;
    s2_o = t2;
    s3_o = t3;
  end

endmodule

// File: rtl/bch_syndrome_seq.sv
// Sequential S1/S2/S3 syndrome generator for BCH(15,7): one word per handshake,
// folded BITS_PER_CYCLE bits per clock, result held until the consumer takes it.
module bch_syndrome_seq
  import bch_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BCH_N-1:0]    in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BCH_N-1:0]    out_word,
  output logic [GF_M-1:0]     out_syn1,
  output logic [GF_M-1:0]     out_syn2,
  output logic [GF_M-1:0]     out_syn3,
  output logic                out_err
);

  localparam logic [3:0] START_CNT = 4'(BCH_N - 1);
  localparam logic [3:0] STEP      = 4'(BITS_PER_CYCLE);
  localparam logic [3:0] LAST_CNT  = 4'(BITS_PER_CYCLE - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [BCH_N-1:0]    word_q;
  logic [GF_M-1:0]     s1_q, s2_q, s3_q;
  logic [GF_M-1:0]     s1_n, s2_n, s3_n;
  logic                err_q;

  bch_syn_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .word_i(word_q),
    .cnt_i (cnt_q),
    .s1_i  (s1_q),
    .s2_i  (s2_q),
    .s3_i  (s3_q),
    .s1_o  (s1_n),
    .s2_o  (s2_n),
    .s3_o  (s3_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Syndromes only move while BUSY, so they are frozen for the whole DONE hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          word_q <= in_word;
          cnt_q  <= START_CNT;
          s1_q   <= '0;
          s2_q   <= '0;
          s3_q   <= '0;
          err_q  <= 1'b0;
        end
        BUSY: begin
          s1_q  <= s1_n;
          s2_q  <= s2_n;
          s3_q  <= s3_n;
          cnt_q <= cnt_q - STEP;
          if (cnt_q == LAST_CNT) err_q <= |{s1_n, s2_n, s3_n};
        end
        default: ;
      endcase
    end
  end

  assign out_word = word_q;
  assign out_syn1 = s1_q;
  assign out_syn2 = s2_q;
  assign out_syn3 = s3_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_bch_syndrome_seq.sv
// Bench for bch_syndrome_seq: four instances (1/3/5/15 bits per cycle) sharing clock and reset,
// checked against known vectors and a power-sum model of r(a^i).
module tb_bch_syndrome_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [3:0]        in_valid_v, in_ready_v, out_valid_v, out_ready_v, err_v;
  logic [3:0][14:0]  in_word_v, out_word_v;
  logic [3:0][3:0]   syn1_v, syn2_v, syn3_v;

  int checks   = 0;
  int failures = 0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      localparam int BPC = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 15;
      bch_syndrome_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_v[g]),
        .in_ready (in_ready_v[g]),
        .in_word  (in_word_v[g]),
        .out_valid(out_valid_v[g]),
        .out_ready(out_ready_v[g]),
        .out_word (out_word_v[g]),
        .out_syn1 (syn1_v[g]),
        .out_syn2 (syn2_v[g]),
        .out_syn3 (syn3_v[g]),
        .out_err  (err_v[g])
      );
    end
  endgenerate

  function automatic int bpc_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      2:       return 5;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a^n by repeated doubling modulo x^4+x+1 (19).
  function automatic logic [3:0] alpha_pow(input int n);
    int v;
    v = 1;
    for (int i = 0; i < (n % 15); i++) begin
      v = v * 2;
      if (v >= 16) v = v ^ 19;
    end
    return v[3:0];
  endfunction

  // S_i = sum over set bits k of a^(i*k).
  function automatic logic [3:0] model_syn(input logic [14:0] w, input int i);
    logic [3:0] s;
    s = 4'h0;
    for (int k = 0; k < 15; k++)
      if (w[k]) s = s ^ alpha_pow(i * k);
    return s;
  endfunction

  // Hand in one word and wait for out_valid; leaves the instance in DONE.
  task automatic run_word(input int d, input logic [14:0] w, output int lat);
    int budget;
    @(negedge clk);
    budget = 0;
    while (!in_ready_v[d] && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("in_ready_wait", 32'(in_ready_v[d]), 32'd1);
    in_valid_v[d] = 1'b1;
    in_word_v[d]  = w;
    @(posedge clk);
    #1;
    in_valid_v[d] = 1'b0;
    in_word_v[d]  = 15'($urandom);
    lat = 1;
    while (!out_valid_v[d] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out(input int d);
    @(negedge clk);
    out_ready_v[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[d] = 1'b0;
    check("release_in_ready", 32'(in_ready_v[d]), 32'd1);
    check("release_out_valid", 32'(out_valid_v[d]), 32'd0);
  endtask

  task automatic check_result(input int d, input logic [14:0] w, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3, input int lat);
    logic e_err;
    e_err = |{e1, e2, e3};
    check($sformatf("valid_d%0d_w%0h", d, w), 32'(out_valid_v[d]), 32'd1);
    check($sformatf("latency_d%0d", d), 32'(lat), 32'(1 + 15 / bpc_of(d)));
    check($sformatf("word_d%0d_w%0h", d, w), 32'(out_word_v[d]), 32'(w));
    check($sformatf("syn1_d%0d_w%0h", d, w), 32'(syn1_v[d]), 32'(e1));
    check($sformatf("syn2_d%0d_w%0h", d, w), 32'(syn2_v[d]), 32'(e2));
    check($sformatf("syn3_d%0d_w%0h", d, w), 32'(syn3_v[d]), 32'(e3));
    check($sformatf("err_d%0d_w%0h", d, w), 32'(err_v[d]), 32'(e_err));
  endtask

  typedef struct {
    logic [14:0] w;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  s3;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int          lat;
    int          ever_valid;
    logic [14:0] w;
    logic [3:0]  h1, h2, h3;
    logic [14:0] hw;

    tbl[0] = '{15'h0000, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{15'h01D1, 4'h0, 4'h0, 4'h0};
    tbl[2] = '{15'h0001, 4'h1, 4'h1, 4'h1};
    tbl[3] = '{15'h0002, 4'h2, 4'h4, 4'h8};
    tbl[4] = '{15'h0010, 4'h3, 4'h5, 4'hF};

    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    in_word_v   = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_in_ready_d%0d", d), 32'(in_ready_v[d]), 32'd1);
      check($sformatf("rst_out_valid_d%0d", d), 32'(out_valid_v[d]), 32'd0);
      check($sformatf("rst_outs_d%0d", d),
            32'({out_word_v[d], syn1_v[d], syn2_v[d], syn3_v[d], err_v[d]}), 32'd0);
    end
    rst_n = 1'b1;

    // Known vectors on every width variant
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 5; i++) begin
        run_word(d, tbl[i].w, lat);
        check_result(d, tbl[i].w, tbl[i].s1, tbl[i].s2, tbl[i].s3, lat);
        release_out(d);
      end
    end

    // Back-pressure: DONE held for 10 cycles while a new word is offered
    run_word(0, 15'h0010, lat);
    check_result(0, 15'h0010, 4'h3, 4'h5, 4'hF, lat);
    hw = out_word_v[0];
    h1 = syn1_v[0];
    h2 = syn2_v[0];
    h3 = syn3_v[0];
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    in_word_v[0]  = 15'h0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid_v[0]), 32'd1);
      check("hold_in_ready", 32'(in_ready_v[0]), 32'd0);
      check("hold_outputs", 32'({out_word_v[0], syn1_v[0], syn2_v[0], syn3_v[0], err_v[0]}),
            32'({hw, h1, h2, h3, 1'b1}));
    end
    in_valid_v[0] = 1'b0;
    release_out(0);
    run_word(0, 15'h0001, lat);
    check_result(0, 15'h0001, 4'h1, 4'h1, 4'h1, lat);
    release_out(0);

    // Reset pulse in the middle of BUSY
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    in_word_v[0]  = 15'h0010;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready_v[0]), 32'd1);
    check("midrst_outs", 32'({out_word_v[0], syn1_v[0], syn2_v[0], syn3_v[0], err_v[0]}), 32'd0);
    ever_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_v[0]) ever_valid = 1;
    end
    check("midrst_no_valid", 32'(ever_valid), 32'd0);
    run_word(0, 15'h0002, lat);
    check_result(0, 15'h0002, 4'h2, 4'h4, 4'h8, lat);
    release_out(0);

    // Random words against the power-sum model, with random consumer stalls
    for (int d = 0; d < 4; d++) begin
      for (int n = 0; n < 12; n++) begin
        if (n % 3 == 0)
          w = (15'h01D1 << $urandom_range(0, 6)) ^ (15'd1 << $urandom_range(0, 14))
              ^ (15'd1 << $urandom_range(0, 14));
        else
          w = 15'($urandom);
        run_word(d, w, lat);
        check_result(d, w, model_syn(w, 1), model_syn(w, 2), model_syn(w, 3), lat);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("stall_valid", 32'(out_valid_v[d]), 32'd1);
        release_out(d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
